// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the decoder/controller.
// Holds the architectural PC, fetches over a req/ack handshake and presents
// one instruction per execute slot, then computes the next PC from the
// controller's PCSrc / PCTargetSel decision.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   PCSrc, PCTargetSel         next-PC selection from the controller
//   ImmExt, ALUResult          branch offset / jalr target operands
//   Stall                      holds the execute slot (only honoured in EXEC)
//   imem_req, imem_addr        fetch request and address (= PC)
//   imem_ack, imem_rdata       one-cycle ack pulse with read data
//   Instr, InstrValid          registered instruction and execute-slot strobe
//   PC, PCPlus4                current PC and PC+4
//   Misaligned                 sticky instruction-address-misaligned flag
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PCSrc,
  input  logic            PCTargetSel,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            Stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     Instr,
  output logic            InstrValid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            Misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_req;
  logic            r_misaligned;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_next_misaligned;
  logic            w_take_ack;
  logic            w_advance;

  always_comb begin
    w_pc_plus4        = r_pc + XLEN'(4);
    w_target          = PCTargetSel ? {ALUResult[XLEN-1:1], 1'b0} : (r_pc + ImmExt);
    w_next_pc         = PCSrc ? w_target : w_pc_plus4;
    w_next_misaligned = (w_next_pc[1:0] != 2'b00);
    // An ack only counts while our request is actually on the bus; this also
    // covers the single post-reset FETCH cycle before imem_req has risen.
    w_take_ack        = (r_state == FETCH) && r_req && imem_ack;
    w_advance         = (r_state == EXEC) && !Stall;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FETCH:   if (w_take_ack) w_state_nxt = EXEC;
      EXEC:    if (!Stall) w_state_nxt = w_next_misaligned ? TRAP : FETCH;
      TRAP:    w_state_nxt = TRAP;
      default: w_state_nxt = FETCH;
    endcase
  end

  // imem_req is registered so that it is low throughout reset and rises on
  // the first edge afterwards; it is simply "will be in FETCH next cycle".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_req        <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == FETCH);
      if (w_take_ack) r_instr <= imem_rdata;
      if (w_advance) begin
        if (w_next_misaligned) r_misaligned <= 1'b1;
        else                   r_pc         <= w_next_pc;
      end
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign Instr      = r_instr;
  assign InstrValid = (r_state == EXEC);
  assign PC         = r_pc;
  assign PCPlus4    = w_pc_plus4;
  assign Misaligned = r_misaligned;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Sequential instruction-fetch stage directly upstream of the decoder/controller in the single-cycle core. It holds the architectural PC, fetches from instruction memory over a req/ack handshake, and presents one instruction per execute slot. It computes the next PC from the controller's PCSrc and target-select outputs. The execute slot is the single cycle in which the controller and datapath act on Instr; all register-file and data-memory write enables downstream are gated by InstrValid.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- PCSrc  in  1  from controller; 1 = take the target, 0 = PC+4
- PCTargetSel  in  1  from controller; 0 = PC+ImmExt (branch/jal), 1 = {ALUResult[XLEN-1:1],1'b0} (jalr)
- ImmExt  in  XLEN  sign-extended immediate from the extender
- ALUResult  in  XLEN  ALU result (jalr target)
- Stall  in  1  holds the execute slot; sampled only in EXEC
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  XLEN  fetch address (= PC)
- imem_ack  in  1  one-cycle pulse; imem_rdata valid the same cycle
- imem_rdata  in  32  fetched instruction word
- Instr  out  32  registered instruction to decoder/controller
- InstrValid  out  1  high during the execute slot
- PC  out  XLEN  current PC
- PCPlus4  out  XLEN  PC+4, combinational, to the result mux
- Misaligned  out  1  sticky instruction-address-misaligned flag

## Operation
- FSM states: FETCH, EXEC, TRAP.
- Reset (asynchronous, reset_n=0): state=FETCH, PC=RESET_PC, Instr=32'h0000_0013 (nop), InstrValid=0, Misaligned=0, imem_req=0. imem_req rises on the first clock edge after reset_n deasserts.
- FETCH:
  - imem_req=1 and imem_addr=PC, both held stable until imem_ack.
  - On imem_ack: Instr <= imem_rdata; next state EXEC.
  - imem_ack outside FETCH is ignored.
- EXEC:
  - InstrValid=1, imem_req=0.
  - If Stall=1: remain in EXEC; PC and Instr hold.
  - Otherwise: NextPC = PCSrc ? Target : PCPlus4, with Target = PCTargetSel ? {ALUResult[XLEN-1:1],1'b0} : PC+ImmExt.
  - If NextPC[1:0]!=2'b00: next state TRAP, Misaligned <= 1, PC holds.
  - Else: PC <= NextPC; next state FETCH.
- TRAP:
  - Terminal until reset. InstrValid=0, imem_req=0, Misaligned=1.
- Arithmetic: all additions are modulo 2^XLEN. PC wraps from 32'hFFFF_FFFC to 0 without a flag.
- PCPlus4 is always PC+4, in every state.
- Reset mid-transaction: an outstanding request is abandoned and imem_req drops immediately. The memory must tolerate the abandoned request.

## Timing
- Minimum 2 cycles per instruction: ack in the same cycle as req gives FETCH→EXEC→FETCH.
- Each memory wait cycle adds 1 cycle.
- InstrValid is high for exactly 1 cycle per instruction, plus 1 cycle per Stall cycle.
- PCSrc, PCTargetSel, ImmExt and ALUResult are sampled only at the EXEC clock edge with Stall=0. They may be X at other times.
- Instr changes only at the FETCH→EXEC edge.
- Misaligned asserts on the edge that leaves EXEC.

## Test plan
- Reset, then sequential fetch with ack in the same cycle as req:
  - Required: imem_addr = 0, 4, 8.
  - InstrValid pulses every second cycle.
  - Instr matches the memory contents.
- Wait states, ack delayed 3 cycles:
  - Required: imem_req and imem_addr stable for 4 cycles.
  - InstrValid stays low until the cycle after ack.
- Branch taken at PC=0x10 with ImmExt=0xFFFF_FFF8, PCSrc=1, PCTargetSel=0:
  - Required: next imem_addr=0x08.
- jalr with ALUResult=0x0000_0101, PCTargetSel=1, PCSrc=1:
  - Required: next PC=0x100.
- Misalignment: PC=0x20 with ImmExt=0x2, PCSrc=1:
  - Required: Misaligned=1, state TRAP, PC stays 0x20.
  - imem_req stays 0 thereafter.
  - Recovery only via reset_n.
- Stall for 2 cycles in EXEC:
  - Required: InstrValid high for 3 cycles, Instr and PC unchanged, no imem_req.
- reset_n asserted while imem_req is high during a wait:
  - Required: imem_req drops asynchronously, PC=RESET_PC.
